usart_receiver: RTL
===================

USART_RECEIVER -- requirements
Module: usart_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per bit period; legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY_MODE, default 0; 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, 2..64.
REQ-006 SHALL have port clk, input, 1 bit; the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; synchronous, active-high.
REQ-008 SHALL have port rx, input, 1 bit; asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS bits; received word, LSB received first.
REQ-010 SHALL have port rx_valid, output, 1 bit; rx_data holds a word.
REQ-011 SHALL have port rx_ready, input, 1 bit; consumer accepts a word.
REQ-012 SHALL have ports frame_err, parity_err and overrun, each output, 1 bit; each a one-cycle error pulse.
REQ-013 SHALL have port busy, output, 1 bit; high while the FSM is outside IDLE.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer, both flops reset to 1; all logic SHALL use only the synchronized value.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and BREAK_WAIT.
REQ-016 In IDLE, a synchronized 1->0 transition SHALL enter START and load the bit counter with CLKS_PER_BIT/2 - 1.
REQ-017 At the START mid-sample, rx=1 SHALL be a false start and return to IDLE with no pulse and no word; rx=0 SHALL enter DATA.
REQ-018 Sampling SHALL occur every CLKS_PER_BIT cycles after the start mid-sample: DATA_BITS data samples shifted LSB-first, then PARITY (if PARITY_MODE != 0), then STOP_BITS stop samples.
REQ-019 A parity mismatch SHALL set an internal flag, and the word SHALL be discarded at frame end with a parity_err pulse.
REQ-020 Any stop sample equal to 0 SHALL pulse frame_err and discard the word; if all data bits and the stop sample are 0 (break), the FSM SHALL enter BREAK_WAIT, which it leaves to IDLE only when rx=1.
REQ-021 If both errors occur in one frame, frame_err and parity_err SHALL pulse in the same cycle.
REQ-022 A good word SHALL be written to the buffer on the cycle after the last stop mid-sample, and rx_valid SHALL rise on the next cycle if the buffer was empty.
REQ-023 A word is consumed on any cycle with rx_valid=1 and rx_ready=1; rx_data SHALL be stable while rx_valid=1 and rx_ready=0.
REQ-024 If a good word completes while the buffer is full, the word SHALL be dropped and overrun SHALL pulse for one cycle; a simultaneous read frees no space for that word.
REQ-025 The FSM SHALL return to IDLE immediately after the last stop sample, so back-to-back frames with no idle gap are received.
REQ-026 When DATA_BITS < 9, unused upper bits are not stored, and rx_data SHALL be exactly DATA_BITS wide.

Reset
REQ-027 On reset the FSM SHALL go to IDLE, counters to 0, and the buffer SHALL be emptied.
REQ-028 On reset rx_valid, frame_err, parity_err, overrun and busy SHALL be 0, and rx_data SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no pulse, and reception SHALL resume at the next falling edge after reset deasserts.

Configuration
REQ-030 With macro USART_RX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry FIFO.
REQ-031 Without USART_RX_FIFO_EN, the buffer SHALL be a single holding register (effective depth 1), FIFO_DEPTH SHALL be ignored, and the overrun rules apply unchanged.

Structure
REQ-032 Package usart_pkg SHALL hold the FSM state enum, the parity-mode constants (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and a parity-function helper.
REQ-033 The buffer SHALL be sub-module usart_rx_fifo, with write port, read valid/ready, a full flag and a DEPTH parameter; it is instantiated only when USART_RX_FIFO_EN is defined.

Verification
REQ-034 Defaults, rx_ready=1, frame 0,01010000,1 (start, LSB-first data, stop) -> rx_data=8'h0A, rx_valid pulses once, no error pulses.
REQ-035 PARITY_MODE=1, byte 8'h0A sent with parity bit 1 -> parity_err pulses once, rx_valid never rises.
REQ-036 rx low for 200 cycles then high (false start) -> busy returns to 0, no pulses; a following frame 8'h55 is received correctly.
REQ-037 USART_RX_FIFO_EN defined, FIFO_DEPTH=4, rx_ready=0, 5 frames 8'h01..8'h05 -> overrun pulses once on the fifth; reading then returns 8'h01..8'h04 in order.
REQ-038 rx held low for 12 bit times (break) -> frame_err pulses once, the FSM stays in BREAK_WAIT until rx=1, no word is delivered.
REQ-039 Reset asserted at the fourth data bit of a frame -> all outputs 0 next cycle; the next full frame 8'hA5 is received correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared definitions for the USART receiver: FSM state encoding, parity modes
// and the expected-parity helper.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP       = 3'd4,
    BREAK_WAIT = 3'd5
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Value the parity bit must carry for the given data (data zero-extended to 9 bits).
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// Receive word FIFO, DEPTH entries (power of two). Used by usart_receiver
// only when USART_RX_FIFO_EN is defined.
module usart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign push     = wr_en && !full;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/usart_receiver.sv
// Oversampling USART receiver with parity/stop checking and a receive buffer.
// Define USART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise one holding register.
//
// state      | meaning
// IDLE       | line idle, waiting for a synchronized falling edge
// START      | counting to the start-bit middle to reject glitches
// DATA       | sampling data bits LSB-first, one per bit period
// PARITY     | sampling and checking the parity bit
// STOP       | sampling stop bit(s); frame result decided at the last one
// BREAK_WAIT | break seen, waiting for the line to return high
module usart_receiver
  import usart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]     LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..64");
  end

  rx_state_e            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_flag;
  logic                 ferr_flag;
  logic                 wr_pending;
  logic                 wr_en;
  logic                 buf_full;
  logic                 buf_valid;
  logic [DATA_BITS-1:0] buf_data;
  logic                 stop_bad;

  assign busy     = (state != IDLE);
  assign stop_bad = ferr_flag || !rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      perr_flag  <= 1'b0;
      ferr_flag  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      wr_pending <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      wr_pending <= 1'b0;
      if (state != IDLE && cnt != '0) cnt <= cnt - CW'(1);
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= HALF_LOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              state     <= DATA;
              cnt       <= FULL_LOAD;
              bit_idx   <= '0;
              perr_flag <= 1'b0;
              ferr_flag <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift <= {rx_sync, shift[DATA_BITS-1:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        PARITY: begin
          if (cnt == '0) begin
            perr_flag <= (rx_sync != parity_bit(9'(shift), PARITY_MODE));
            state     <= STOP;
            cnt       <= FULL_LOAD;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (stop_idx == LAST_STOP) begin
              // Frame verdict; the buffer write or error pulses land on the next cycle.
              frame_err  <= stop_bad;
              parity_err <= perr_flag;
              wr_pending <= !stop_bad && !perr_flag;
              state      <= (!rx_sync && shift == '0) ? BREAK_WAIT : IDLE;
            end else begin
              ferr_flag <= stop_bad;
              stop_idx  <= 1'b1;
              cnt       <= FULL_LOAD;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_en   = wr_pending && !buf_full;
  assign overrun = wr_pending && buf_full;

`ifdef USART_RX_FIFO_EN
  usart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (shift),
    .full    (buf_full),
    .rd_valid(buf_valid),
    .rd_ready(rx_ready),
    .rd_data (buf_data)
  );
`else
  logic                 hold_valid;
  logic [DATA_BITS-1:0] hold_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (wr_en) begin
      hold_valid <= 1'b1;
      hold_data  <= shift;
    end else if (hold_valid && rx_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign buf_full  = hold_valid;
  assign buf_valid = hold_valid;
  assign buf_data  = hold_data;
`endif

  assign rx_valid = buf_valid;
  assign rx_data  = buf_valid ? buf_data : '0;

endmodule
